// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Parametrised barrel shifter for the integer datapath. Supports logical
//   right (SRL), arithmetic right (SRA), logical left (SLL) and rotate right
//   (ROR) on a WIDTH-bit operand. The SHFT_LEN mux layers are grouped
//   REG_EVERY at a time into NSTG registered stages. An elastic valid/ready
//   pipeline gives one op per cycle with backpressure. A sideband tag rides
//   along unmodified.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   synchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  stage 0 can load this cycle
//   in_x       in   operand [WIDTH]
//   in_shamt   in   shift amount [SHFT_LEN], 0..WIDTH-1
//   in_op      in   00 SRL, 01 SRA, 10 SLL, 11 ROR
//   in_tag     in   request tag [TAG_W]
//   out_valid  out  result valid (last stage valid)
//   out_ready  in   consumer accepts result
//   out_z      out  shifted result [WIDTH]
//   out_tag    out  tag of the result [TAG_W]
module pipelined_shifter #(
  parameter int WIDTH     = 32,
  parameter int SHFT_LEN  = 5,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [SHFT_LEN-1:0] in_shamt,
  input  logic [1:0]          in_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_z,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int NSTG = (SHFT_LEN + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  // One mux layer shifting by k. The SRA fill comes from the bit captured
  // at the input, never from the partially shifted data.
  function automatic logic [WIDTH-1:0] shift_layer(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             fill,
    input int unsigned      k
  );
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] ext_sh;
    logic [WIDTH-1:0]      r;
    ext    = {fill, d};
    ext_sh = ext >>> k;
    case (op)
      OP_SRL:  r = d >> k;
      OP_SRA:  r = ext_sh[WIDTH-1:0];
      OP_SLL:  r = d << k;
      default: r = (d >> k) | (d << (WIDTH - k));
    endcase
    return r;
  endfunction

  // Stage registers
  logic                vld_p  [NSTG];
  logic [WIDTH-1:0]    z_p    [NSTG];
  logic [SHFT_LEN-1:0] sh_p   [NSTG];
  logic [1:0]          op_p   [NSTG];
  logic                fill_p [NSTG];
  logic [TAG_W-1:0]    tag_p  [NSTG];

  // Stage inputs (input port for stage 0, previous register otherwise)
  logic                src_vld  [NSTG];
  logic [WIDTH-1:0]    src_z    [NSTG];
  logic [SHFT_LEN-1:0] src_sh   [NSTG];
  logic [1:0]          src_op   [NSTG];
  logic                src_fill [NSTG];
  logic [TAG_W-1:0]    src_tag  [NSTG];

  logic [WIDTH-1:0]    z_nxt    [NSTG];
  logic                ld       [NSTG+1];

  // Load enables ripple back from the consumer: a stage loads when it is
  // empty or its content moves on this cycle, so bubbles collapse.
  always_comb begin
    ld[NSTG] = out_ready;
    for (int s = NSTG - 1; s >= 0; s--) begin
      ld[s] = !vld_p[s] || ld[s+1];
    end
  end

  assign in_ready = ld[0];

  always_comb begin
    src_vld[0]  = in_valid;
    src_z[0]    = in_x;
    src_sh[0]   = in_shamt;
    src_op[0]   = in_op;
    src_fill[0] = in_x[WIDTH-1];
    src_tag[0]  = in_tag;
    for (int s = 1; s < NSTG; s++) begin
      src_vld[s]  = vld_p[s-1];
      src_z[s]    = z_p[s-1];
      src_sh[s]   = sh_p[s-1];
      src_op[s]   = op_p[s-1];
      src_fill[s] = fill_p[s-1];
      src_tag[s]  = tag_p[s-1];
    end
  end

  // Mux layers: layer i (shift by 2^i) belongs to stage i / REG_EVERY.
  // The full shamt is carried; each stage only looks at its own bits.
  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      z_nxt[s] = src_z[s];
      for (int i = 0; i < SHFT_LEN; i++) begin
        if (((i / REG_EVERY) == s) && src_sh[s][i]) begin
          z_nxt[s] = shift_layer(z_nxt[s], src_op[s], src_fill[s], 32'd1 << i);
        end
      end
    end
  end

  // Stage register boundary: data is written only when a valid op enters,
  // so bubbles leave the payload untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTG; s++) begin
        vld_p[s]  <= 1'b0;
        z_p[s]    <= '0;
        sh_p[s]   <= '0;
        op_p[s]   <= '0;
        fill_p[s] <= 1'b0;
        tag_p[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NSTG; s++) begin
        if (ld[s]) begin
          vld_p[s] <= src_vld[s];
          if (src_vld[s]) begin
            z_p[s]    <= z_nxt[s];
            sh_p[s]   <= src_sh[s];
            op_p[s]   <= src_op[s];
            fill_p[s] <= src_fill[s];
            tag_p[s]  <= src_tag[s];
          end
        end
      end
    end
  end

  assign out_valid = vld_p[NSTG-1];
  assign out_z     = z_p[NSTG-1];
  assign out_tag   = tag_p[NSTG-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: default instance plus two parameter variants,
// each checked every cycle against an arithmetic reference model.
module tb_pipelined_shifter;

  localparam int NSTG   = 5;
  localparam int NSTG8  = 2;
  localparam int NSTG64 = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_x, out_z;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  logic        s8_in_valid, s8_in_ready, s8_out_valid;
  logic [7:0]  s8_in_x, s8_out_z;
  logic [2:0]  s8_in_shamt;
  logic [1:0]  s8_in_op;
  logic [3:0]  s8_in_tag, s8_out_tag;

  logic        s64_in_valid, s64_in_ready, s64_out_valid;
  logic [63:0] s64_in_x, s64_out_z;
  logic [5:0]  s64_in_shamt;
  logic [1:0]  s64_in_op;
  logic [3:0]  s64_in_tag, s64_out_tag;

  pipelined_shifter #(.WIDTH(32), .SHFT_LEN(5), .REG_EVERY(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag)
  );

  pipelined_shifter #(.WIDTH(8), .SHFT_LEN(3), .REG_EVERY(2), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .in_x(s8_in_x), .in_shamt(s8_in_shamt), .in_op(s8_in_op), .in_tag(s8_in_tag),
    .out_valid(s8_out_valid), .out_ready(1'b1), .out_z(s8_out_z), .out_tag(s8_out_tag)
  );

  pipelined_shifter #(.WIDTH(64), .SHFT_LEN(6), .REG_EVERY(4), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(s64_in_valid), .in_ready(s64_in_ready),
    .in_x(s64_in_x), .in_shamt(s64_in_shamt), .in_op(s64_in_op), .in_tag(s64_in_tag),
    .out_valid(s64_out_valid), .out_ready(1'b1), .out_z(s64_out_z), .out_tag(s64_out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] z;
    logic [63:0] tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  exp_t q64[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int run = 0;
  int max_run = 0;
  int last_ret = -10;
  bit lat_mode = 1'b0;
  bit stall_prev = 1'b0;
  logic [31:0] prev_z;
  logic [3:0]  prev_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain shift arithmetic on a w-bit value held in 64 bits.
  function automatic logic [63:0] model(input logic [63:0] x, input int sh,
                                        input logic [1:0] op, input int w);
    logic [63:0] m, xm, r;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm = x & m;
    case (op)
      2'b00: r = xm >> sh;
      2'b01: begin
        r = xm >> sh;
        if (((xm >> (w - 1)) & 64'd1) != 64'd0) r = r | (m & ~(m >> sh));
      end
      2'b10: r = (xm << sh) & m;
      default: r = ((xm >> sh) | (xm << (w - sh))) & m;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Main instance compare process, sampled mid-cycle.
  always @(negedge clk) begin : mon0
    exp_t e;
    logic exp_rdy;
    if (!rst_n) begin
      q0.delete();
      stall_prev = 1'b0;
    end else begin
      exp_rdy = (q0.size() < NSTG) || out_ready;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_z", 64'(out_z), 64'(prev_z));
        check("stall_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        if (q0.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = q0[0];
          check("out_z", 64'(out_z), e.z);
          check("out_tag", 64'(out_tag), e.tag);
          if (out_ready) begin
            if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(NSTG));
            void'(q0.pop_front());
            run = (last_ret == cyc - 1) ? run + 1 : 1;
            last_ret = cyc;
            if (run > max_run) max_run = run;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_z = out_z;
      prev_tag = out_tag;
      if (in_valid && in_ready) begin
        q0.push_back('{z: model(64'(in_x), int'(in_shamt), in_op, 32),
                       tag: 64'(in_tag), cyc: cyc, lat: lat_mode});
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (s8_out_valid) begin
        if (q8.size() == 0) begin
          check("s8_spurious", 64'(s8_out_valid), 64'd0);
        end else begin
          e = q8.pop_front();
          check("s8_z", 64'(s8_out_z), e.z);
          check("s8_tag", 64'(s8_out_tag), e.tag);
          check("s8_latency", 64'(cyc - e.cyc), 64'(NSTG8));
        end
      end
      if (s8_in_valid && s8_in_ready)
        q8.push_back('{z: model(64'(s8_in_x), int'(s8_in_shamt), s8_in_op, 8),
                       tag: 64'(s8_in_tag), cyc: cyc, lat: 1'b1});
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst_n) begin
      q64.delete();
    end else begin
      if (s64_out_valid) begin
        if (q64.size() == 0) begin
          check("s64_spurious", 64'(s64_out_valid), 64'd0);
        end else begin
          e = q64.pop_front();
          check("s64_z", s64_out_z, e.z);
          check("s64_tag", 64'(s64_out_tag), e.tag);
          check("s64_latency", 64'(cyc - e.cyc), 64'(NSTG64));
        end
      end
      if (s64_in_valid && s64_in_ready)
        q64.push_back('{z: model(s64_in_x, int'(s64_in_shamt), s64_in_op, 64),
                        tag: 64'(s64_in_tag), cyc: cyc, lat: 1'b1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input int sh, input logic [1:0] op);
    in_valid = 1'b1;
    in_x = x;
    in_shamt = 5'(sh);
    in_op = op;
    in_tag = 4'(n_acc);
    step();
  endtask

  task automatic rand_req(input bit v);
    in_valid = v;
    in_x = $urandom;
    in_shamt = 5'($urandom);
    in_op = 2'($urandom);
    in_tag = 4'(n_acc);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && q0.size() != 0; i++) step();
    check("drain_empty", 64'(q0.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst_n = 1'b0;
    out_ready = 1'($urandom);
    rand_req(1'b1);
    s8_in_valid = 1'b1;  s8_in_x = 8'($urandom);   s8_in_shamt = 3'd1;  s8_in_op = 2'd0;  s8_in_tag = 4'd0;
    s64_in_valid = 1'b1; s64_in_x = {$urandom, $urandom}; s64_in_shamt = 6'd1; s64_in_op = 2'd0; s64_in_tag = 4'd0;

    // Pin the reference model with hand-computed values.
    check("model_srl", model(64'h800000F1, 4, 2'b00, 32), 64'h0800000F);
    check("model_sra", model(64'h800000F1, 4, 2'b01, 32), 64'hF800000F);
    check("model_sll", model(64'h800000F1, 4, 2'b10, 32), 64'h00000F10);
    check("model_ror", model(64'h800000F1, 4, 2'b11, 32), 64'h1800000F);
    check("model_sra31", model(64'h80000000, 31, 2'b01, 32), 64'hFFFFFFFF);
    check("model_ror8", model(64'h81, 7, 2'b11, 8), 64'h03);
    check("model_ror64", model(64'h1, 63, 2'b11, 64), 64'h2);

    // Reset with traffic present at the input.
    step();
    rand_req(1'b1);
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_z", 64'(out_z), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_s8_out_valid", 64'(s8_out_valid), 64'd0);
    check("rst_s64_out_z", s64_out_z, 64'd0);
    s8_in_valid = 1'b0;
    s64_in_valid = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Directed ops, back to back, with exact latency.
    lat_mode = 1'b1;
    send(32'h800000F1, 4, 2'b00);
    send(32'h800000F1, 4, 2'b01);
    send(32'h800000F1, 4, 2'b10);
    send(32'h800000F1, 4, 2'b11);
    send(32'h80000000, 31, 2'b01);
    for (int op = 0; op < 4; op++) send($urandom, 0, 2'(op));
    send(32'h12345678, 31, 2'b11);
    drain();

    // Throughput: 100 back-to-back requests.
    max_run = 0;
    for (int i = 0; i < 100; i++) begin
      rand_req(1'b1);
      step();
    end
    drain();
    check("tput_consecutive", 64'(max_run), 64'd100);

    // Bubble collapse and stall hold.
    lat_mode = 1'b0;
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 2; i++) begin
      rand_req(1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    for (int i = 0; i < NSTG + 8; i++) begin
      rand_req(1'b1);
      step();
    end
    check("bubble_accepts", 64'(n_acc - a0), 64'(NSTG));
    check("bubble_in_ready", 64'(in_ready), 64'd0);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_req($urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 9) < 6;
      step();
    end
    drain();

    // Reset with operations in flight, then a cold start.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b1);
      step();
    end
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_z", 64'(out_z), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    lat_mode = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b1);
      step();
    end
    drain();

    // Parameter variants, including rotate by WIDTH-1.
    for (int i = 0; i < 200; i++) begin
      s8_in_valid = $urandom_range(0, 3) != 0;
      s8_in_x = 8'($urandom);
      s8_in_shamt = 3'($urandom);
      s8_in_op = 2'($urandom);
      s8_in_tag = 4'(i);
      s64_in_valid = $urandom_range(0, 3) != 0;
      s64_in_x = {$urandom, $urandom};
      s64_in_shamt = 6'($urandom);
      s64_in_op = 2'($urandom);
      s64_in_tag = 4'(i);
      if (i % 5 == 0) begin
        s8_in_op = 2'b11;  s8_in_shamt = 3'd7;
        s64_in_op = 2'b11; s64_in_shamt = 6'd63;
      end
      step();
    end
    s8_in_valid = 1'b0;
    s64_in_valid = 1'b0;
    repeat (4) step();
    check("s8_drain_empty", 64'(q8.size()), 64'd0);
    check("s64_drain_empty", 64'(q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
